// File: rtl/uart_rx_packer_if.sv
// Packet stream between the UART receive packer and the MVM core.
// The master drives valid/data; the slave drives ready.
interface uart_rx_packer_if #(
  parameter int unsigned W_BUS = 24
);
  logic             m_valid;
  logic             m_ready;
  logic [W_BUS-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_packer.sv
// 8N1 UART receiver that packs N_WORDS bytes, first byte in the low bits,
// into one bus word on a valid/ready stream; never stalls on backpressure.
module uart_rx_packer #(
  parameter int unsigned CLOCKS_PER_PULSE = 33,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned N_WORDS          = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  uart_rx_packer_if.master m,
  output logic             m_err,
  output logic             m_overflow,
  output logic             rx_busy
);

  localparam int unsigned W_BUS = N_WORDS * BITS_PER_WORD;
  localparam int unsigned CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned BIT_W = $clog2(BITS_PER_WORD + 1);
  localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic                     rx_meta_q;
  logic                     rx_s_q;

  state_e                   state_q,  state_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;
  logic [BIT_W-1:0]         bit_q,    bit_d;
  logic [BITS_PER_WORD-1:0] shift_q,  shift_d;
  logic [IDX_W-1:0]         idx_q,    idx_d;
  logic [W_BUS-1:0]         asm_q,    asm_d;
  logic                     done_q,   done_d;
  logic                     err_q,    err_d;
  logic                     busy_q,   busy_d;

  logic                     valid_q,  valid_d;
  logic [W_BUS-1:0]         data_q,   data_d;
  logic                     ovf_q,    ovf_d;
  logic                     out_free_c;

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Receive FSM: mid-bit sampling, byte assembly and packet completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          shift_d = BITS_PER_WORD'({rx_s_q, shift_q} >> 1);
          cnt_d   = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s_q) begin
            asm_d[idx_q*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
            state_d = S_IDLE;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A held-low line (break) must not be mistaken for a new start bit.
      S_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Output register: loads a completed packet if free, otherwise drops it.
  assign out_free_c = !valid_q || m.m_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = 1'b0;

    if (valid_q && m.m_ready) begin
      valid_d = 1'b0;
    end

    if (done_q) begin
      if (out_free_c) begin
        valid_d = 1'b1;
        data_d  = asm_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign m.m_valid  = valid_q;
  assign m.m_data   = data_q;
  assign m_err      = err_q;
  assign m_overflow = ovf_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: a packet-level expectation queue checked
// against every stream transfer, plus hold-stability and pulse-count checks.
`timescale 1ns/1ps
module tb_uart_rx_packer;

  localparam int unsigned CPP   = 33;
  localparam int unsigned BPW   = 8;
  localparam int unsigned NW    = 3;
  localparam int unsigned W_BUS = NW * BPW;

  logic clk;
  logic rstn;
  logic rx;
  logic m_err;
  logic m_overflow;
  logic rx_busy;

  uart_rx_packer_if #(.W_BUS(W_BUS)) bus ();

  uart_rx_packer #(
    .CLOCKS_PER_PULSE (CPP),
    .BITS_PER_WORD    (BPW),
    .N_WORDS          (NW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .m          (bus.master),
    .m_err      (m_err),
    .m_overflow (m_overflow),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int xfer_cnt;
  int err_cnt;
  int ovf_cnt;
  int ready_mode;   // 0 = low, 1 = high, 2 = random per cycle

  logic [W_BUS-1:0] exp_q[$];

  logic             prev_valid;
  logic             prev_ready;
  logic [W_BUS-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W_BUS-1:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
    logic [W_BUS-1:0] w;
    w = '0;
    w = w + (W_BUS'(b0) << 0);
    w = w + (W_BUS'(b1) << 8);
    w = w + (W_BUS'(b2) << 16);
    return w;
  endfunction

  // One 8N1 frame, LSB first, one full bit period per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPP);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPP);
    end
    rx = stop_bit;
    tick(CPP);
    if (stop_bit) tick(2);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b1);
    send_frame(b1, 1'b1);
    send_frame(b2, 1'b1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_m_valid"},    32'(bus.m_valid),  32'd0);
    chk({name, "_m_data"},     32'(bus.m_data),   32'd0);
    chk({name, "_m_err"},      32'(m_err),        32'd0);
    chk({name, "_m_overflow"}, 32'(m_overflow),   32'd0);
    chk({name, "_rx_busy"},    32'(rx_busy),      32'd0);
  endtask

  // Ready driver, changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.m_ready = 1'b0;
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: transfers against the expectation queue, hold stability, pulse counts.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = '0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(bus.m_valid), 32'd1);
        chk("hold_data",  32'(bus.m_data),  32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got data 0x%0h, expected no transfer (t=%0t)",
                   bus.m_data, $time);
        end else begin
          chk("pkt_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
      end
      if (m_err)      err_cnt++;
      if (m_overflow) ovf_cnt++;
      if (m_err && m_overflow) begin
        checks++;
        errors++;
        $display("FAIL err_ovf_overlap: got both pulses, expected at most one (t=%0t)", $time);
      end
      prev_valid = bus.m_valid;
      prev_ready = bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, e0, o0;
    logic [7:0] b0, b1, b2;

    checks     = 0;
    errors     = 0;
    xfer_cnt   = 0;
    err_cnt    = 0;
    ovf_cnt    = 0;
    ready_mode = 1;
    bus.m_ready = 1'b1;
    rx   = 1'b1;
    rstn = 1'b0;
    tick(3);
    check_all_zero("reset");
    rstn = 1'b1;
    tick(5);

    // 1: single packet, ready high.
    x0 = xfer_cnt; e0 = err_cnt; o0 = ovf_cnt;
    exp_q.push_back(24'h654321);
    send_packet(8'h21, 8'h43, 8'h65);
    wait_drain("t1", 50);
    tick(3);
    chk("t1_xfers",   32'(xfer_cnt - x0), 32'd1);
    chk("t1_valid",   32'(bus.m_valid),   32'd0);
    chk("t1_err",     32'(err_cnt - e0),  32'd0);
    chk("t1_ovf",     32'(ovf_cnt - o0),  32'd0);

    // 2: backpressure for 500 cycles, then a single transfer.
    ready_mode = 0;
    tick(2);
    x0 = xfer_cnt;
    exp_q.push_back(24'h654321);
    send_packet(8'h21, 8'h43, 8'h65);
    tick(500);
    chk("t2_held_valid", 32'(bus.m_valid), 32'd1);
    chk("t2_held_data",  32'(bus.m_data),  32'h654321);
    ready_mode = 1;
    wait_drain("t2", 10);
    tick(3);
    chk("t2_xfers", 32'(xfer_cnt - x0), 32'd1);
    chk("t2_valid", 32'(bus.m_valid),   32'd0);

    // 3: framing error with a break, then a clean packet from slot 0.
    e0 = err_cnt;
    send_frame(8'hAA, 1'b0);
    tick(40);
    chk("t3_busy_break", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    tick(6);
    chk("t3_busy_idle", 32'(rx_busy),      32'd0);
    chk("t3_err_count", 32'(err_cnt - e0), 32'd1);
    exp_q.push_back(24'h030201);
    send_packet(8'h01, 8'h02, 8'h03);
    wait_drain("t3", 50);

    // 4: short low glitch is rejected.
    e0 = err_cnt;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    chk("t4_busy",  32'(rx_busy),      32'd0);
    chk("t4_err",   32'(err_cnt - e0), 32'd0);
    exp_q.push_back(24'hC0B0A0);
    send_packet(8'hA0, 8'hB0, 8'hC0);
    wait_drain("t4", 50);

    // 5: second packet dropped while the first is held.
    ready_mode = 0;
    tick(2);
    x0 = xfer_cnt; o0 = ovf_cnt;
    exp_q.push_back(24'h332211);
    send_packet(8'h11, 8'h22, 8'h33);
    send_packet(8'h44, 8'h55, 8'h66);
    tick(5);
    chk("t5_ovf",        32'(ovf_cnt - o0), 32'd1);
    chk("t5_held_valid", 32'(bus.m_valid),  32'd1);
    chk("t5_held_data",  32'(bus.m_data),   32'h332211);
    ready_mode = 1;
    wait_drain("t5", 10);
    tick(40);
    chk("t5_valid", 32'(bus.m_valid),   32'd0);
    chk("t5_xfers", 32'(xfer_cnt - x0), 32'd1);

    // 6: reset mid-frame discards the partial packet.
    send_frame(8'h7F, 1'b1);
    rx = 1'b0;
    tick(CPP);
    rx = 1'b1;
    tick(50);
    rstn = 1'b0;
    tick(2);
    check_all_zero("t6_reset");
    rx = 1'b1;
    tick(2);
    rstn = 1'b1;
    tick(5);
    exp_q.push_back(24'h030201);
    send_packet(8'h01, 8'h02, 8'h03);
    wait_drain("t6", 50);

    // 7: random packets with random ready.
    ready_mode = 2;
    o0 = ovf_cnt; e0 = err_cnt; x0 = xfer_cnt;
    for (int p = 0; p < 10; p++) begin
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      exp_q.push_back(pack(b0, b1, b2));
      send_packet(b0, b1, b2);
      tick(int'($urandom_range(0, 20)));
    end
    wait_drain("t7", 400);
    chk("t7_ovf",   32'(ovf_cnt - o0),  32'd0);
    chk("t7_err",   32'(err_cnt - e0),  32'd0);
    chk("t7_xfers", 32'(xfer_cnt - x0), 32'd10);

    ready_mode = 1;
    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
